ahblite_busmatrix_arbiter_rr: RTL

- Round-robin arbiter for one AHB-Lite bus-matrix output stage shared by NUM_PORTS input stages.
- Drives the output-stage mux select (PORT_SEL) and no-port indication (PORT_NOSEL).
- Re-arbitrates only at AHB transfer boundaries (HREADY high) and never inside a defined-length or undefined-length burst.
- Replaces the fixed single-requester arbiters wherever a slave such as UART, RAM or GPIO is reachable from more than one master.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/ahblite_burst_tracker.sv | 70 +++++++
 rtl/ahblite_busmatrix_arbiter_rr.sv | 78 +++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite transfer/burst encodings shared by the bus-matrix blocks.
// Also provides burst_len_m1 for fixed-length burst beat counting.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    logic [3:0] r;
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   r = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   r = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: r = 4'd15;
      default:                      r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahblite_burst_tracker.sv
// Beat counter and undefined-length flag that lock arbitration in bursts.
// ARB_MASTLOCK_EN adds an HMASTLOCK lock with a one-cycle trailing hold.
module ahblite_burst_tracker
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       hready,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
`ifdef ARB_MASTLOCK_EN
  input  logic       hmastlock,
`endif
  output logic       hold_next,
  output logic       arb_hold
);

  logic [3:0] cnt_q, cnt_d;
  logic       undef_q, undef_d;

  always_comb begin
    cnt_d   = cnt_q;
    undef_d = 1'b0;
    if (!hsel) begin
      cnt_d = '0;
    end else begin
      unique case (htrans)
        HTRANS_NONSEQ: begin
          cnt_d   = burst_len_m1(hburst);
          undef_d = (hburst == HBURST_INCR);
        end
        HTRANS_SEQ: begin
          cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          undef_d = undef_q;
        end
        HTRANS_BUSY: undef_d = undef_q;
        default:     cnt_d   = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q   <= '0;
      undef_q <= 1'b0;
    end else if (hready) begin
      cnt_q   <= cnt_d;
      undef_q <= undef_d;
    end
  end

`ifdef ARB_MASTLOCK_EN
  logic lock_q, lock_d;
  assign lock_d = hmastlock & hsel;

  // lock_q stretches the hold over the IDLE that follows the locked run
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    lock_q <= 1'b0;
    else if (hready) lock_q <= lock_d;
  end

  assign hold_next = (cnt_d != 4'd0) | undef_d | lock_d | lock_q;
  assign arb_hold  = (cnt_q != 4'd0) | undef_q | lock_d | lock_q;
`else
  assign hold_next = (cnt_d != 4'd0) | undef_d;
  assign arb_hold  = (cnt_q != 4'd0) | undef_q;
`endif

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Round-robin arbiter for one AHB-Lite bus-matrix output stage.
// Build with ARB_MASTLOCK_EN to honour HMASTLOCK_Outputstage.
module ahblite_busmatrix_arbiter_rr
  import ahb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int SEL_W     = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] REQ_SUB,
  input  logic                 HREADY_Outputstage,
  input  logic                 HSEL_Outputstage,
  input  logic [1:0]           HTRANS_Outputstage,
  input  logic [2:0]           HBURST_Outputstage,
`ifdef ARB_MASTLOCK_EN
  input  logic                 HMASTLOCK_Outputstage,
`endif
  output logic [SEL_W-1:0]     PORT_SEL_ARBITER,
  output logic                 PORT_NOSEL_ARBITER,
  output logic                 ARB_HOLD
);

  logic             hold_next;
  logic [SEL_W-1:0] ptr_q, sel_q, win;
  logic             nosel_q, any;
  int               idx;

  ahblite_burst_tracker u_trk (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hready    (HREADY_Outputstage),
    .hsel      (HSEL_Outputstage),
    .htrans    (HTRANS_Outputstage),
    .hburst    (HBURST_Outputstage),
`ifdef ARB_MASTLOCK_EN
    .hmastlock (HMASTLOCK_Outputstage),
`endif
    .hold_next (hold_next),
    .arb_hold  (ARB_HOLD)
  );

  // Scan from far to near so the port closest after ptr wins
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j == idx && REQ_SUB[j]) begin
          any = 1'b1;
          win = SEL_W'(j);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q   <= SEL_W'(NUM_PORTS - 1);
      sel_q   <= '0;
      nosel_q <= 1'b1;
    end else if (HREADY_Outputstage && !hold_next) begin
      if (any) begin
        ptr_q   <= win;
        sel_q   <= win;
        nosel_q <= 1'b0;
      end else begin
        nosel_q <= ~HSEL_Outputstage;
      end
    end
  end

  assign PORT_SEL_ARBITER   = sel_q;
  assign PORT_NOSEL_ARBITER = nosel_q;

endmodule
